mem_wb_stage: RTL

MEM/WB pipeline register and write-back datapath for the 5-stage MIPS core. It captures memory-stage results at each clock edge and performs load byte/halfword extraction and sign/zero extension. It selects between memory data and the ALU result, and drives the single write-back port (WriteRegister, WriteData, RegisterWrite). That port is consumed by the register file and by the write-back forwarding unit in ID. It also flags misaligned loads and counts retired instructions.

---
 rtl/mem_wb_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back datapath: load lane extraction,
// sign/zero extension, misaligned-load detection and retired-instruction count.
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        MemValid,
  input  logic        MemRegWrite,
  input  logic        MemToReg,
  input  logic [2:0]  MemLoadType,
  input  logic [4:0]  MemWriteRegister,
  input  logic [31:0] MemReadData,
  input  logic [31:0] ALUResult,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegisterWrite,
  output logic        AlignError,
  output logic [31:0] RetireCount
);

  typedef enum logic [2:0] {
    LdW  = 3'b000,
    LdH  = 3'b001,
    LdHu = 3'b010,
    LdB  = 3'b011,
    LdBu = 3'b100
  } loadType_e;

  logic        validQ;
  logic        regWriteQ;
  logic        memToRegQ;
  logic [2:0]  loadTypeQ;
  logic [4:0]  writeRegisterQ;
  logic [31:0] readDataQ;
  logic [31:0] aluResultQ;
  logic [31:0] retireCountQ;

  logic [1:0]  offset;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic        misaligned;

  // Pipeline register: flush inserts a bubble, stall holds, otherwise capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validQ         <= 1'b0;
      regWriteQ      <= 1'b0;
      memToRegQ      <= 1'b0;
      loadTypeQ      <= '0;
      writeRegisterQ <= '0;
      readDataQ      <= '0;
      aluResultQ     <= '0;
    end else if (Flush) begin
      validQ         <= 1'b0;
      regWriteQ      <= 1'b0;
      memToRegQ      <= 1'b0;
      loadTypeQ      <= '0;
      writeRegisterQ <= '0;
      readDataQ      <= '0;
      aluResultQ     <= '0;
    end else if (!Stall) begin
      validQ         <= MemValid;
      regWriteQ      <= MemRegWrite;
      memToRegQ      <= MemToReg;
      loadTypeQ      <= MemLoadType;
      writeRegisterQ <= MemWriteRegister;
      readDataQ      <= MemReadData;
      aluResultQ     <= ALUResult;
    end
  end

  // Retire counter: a valid instruction leaves WB when it is not held, or when flushed out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retireCountQ <= '0;
    end else if (validQ && (!Stall || Flush)) begin
      retireCountQ <= retireCountQ + 32'd1;
    end
  end

  // Big-endian lane selection and extension of the load data
  always_comb begin
    offset  = aluResultQ[1:0];
    byteSel = '0;
    case (offset)
      2'd0: byteSel = readDataQ[31:24];
      2'd1: byteSel = readDataQ[23:16];
      2'd2: byteSel = readDataQ[15:8];
      default: byteSel = readDataQ[7:0];
    endcase
    halfSel = offset[1] ? readDataQ[15:0] : readDataQ[31:16];

    loadData   = readDataQ;
    misaligned = (offset != 2'd0);
    case (loadTypeQ)
      LdH: begin
        loadData   = {{16{halfSel[15]}}, halfSel};
        misaligned = offset[0];
      end
      LdHu: begin
        loadData   = {16'h0000, halfSel};
        misaligned = offset[0];
      end
      LdB: begin
        loadData   = {{24{byteSel[7]}}, byteSel};
        misaligned = 1'b0;
      end
      LdBu: begin
        loadData   = {24'h000000, byteSel};
        misaligned = 1'b0;
      end
      default: begin
        loadData   = readDataQ;
        misaligned = (offset != 2'd0);
      end
    endcase
  end

  // Write-back port driven purely from registered state
  always_comb begin
    AlignError    = validQ & memToRegQ & misaligned;
    WriteData     = memToRegQ ? loadData : aluResultQ;
    WriteRegister = writeRegisterQ;
    RegisterWrite = validQ & regWriteQ & ~AlignError;
    RetireCount   = retireCountQ;
  end

endmodule
